// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Request/response bundle between the two SRAM requesters (CPU memory path on
// index 0, debug/IO loader on index 1) and the SRAM arbiter.
//
//   req_valid[i]   requester i has a pending request
//   req_we[i]      1 = write, 0 = read
//   req_addr0/1    word address per requester
//   req_wdata0/1   write data per requester
//   req_be0/1      byte enables, [1] upper byte, [0] lower byte, active-high
//   req_ready      one-hot, request accepted in the cycle the bit is high
//   rsp_valid      one-hot, one-cycle completion pulse
//   rsp_rdata      read data, valid with rsp_valid and held afterwards
//
// master: requester side.  slave: arbiter side.
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [15:0]       req_wdata0;
    logic [15:0]       req_wdata1;
    logic [1:0]        req_be0;
    logic [1:0]        req_be1;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [15:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr0, req_addr1,
               req_wdata0, req_wdata1, req_be0, req_be1,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1,
               req_wdata0, req_wdata1, req_be0, req_be1,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Round-robin arbiter and access sequencer for the shared 16-bit asynchronous
// SRAM. One request is granted at a time; the granted access runs for
// RD_CYCLES or WR_CYCLES cycles with active-low strobes, then a one-cycle
// response pulse is issued. This block is the only driver of the Mem_* pins.
//
// Ports
//   Clk               clock, rising edge
//   Reset             synchronous, active-high
//   bus               sram_arbiter_if.slave request/response bundle
//   o_Mem_ADDR        SRAM word address
//   o_Data_to_SRAM    write data toward the pad driver
//   o_Data_oe         pad driver enable for o_Data_to_SRAM
//   i_Data_from_SRAM  SRAM read bus
//   o_Mem_CE/UB/LB/OE/WE  SRAM strobes, active-low
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] o_Mem_ADDR,
    output logic [15:0]       o_Data_to_SRAM,
    output logic              o_Data_oe,
    input  logic [15:0]       i_Data_from_SRAM,
    output logic              o_Mem_CE,
    output logic              o_Mem_UB,
    output logic              o_Mem_LB,
    output logic              o_Mem_OE,
    output logic              o_Mem_WE
);

    localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            r_state, w_state;
    logic [3:0]        r_cnt, w_cnt;
    logic              r_gnt, w_gnt;
    logic              r_we, w_we;
    logic              r_last, w_last;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [15:0]       r_wdata, w_wdata;
    logic              r_ce, w_ce;
    logic              r_ub, w_ub;
    logic              r_lb, w_lb;
    logic              r_oe, w_oe;
    logic              r_wen, w_wen;
    logic              r_doe, w_doe;
    logic [1:0]        r_rsp_valid, w_rsp_valid;
    logic [15:0]       r_rdata, w_rdata;
    logic [1:0]        w_ready;
    logic              w_sel;
    logic [1:0]        w_be;

    // Next-state, arbitration and next strobe values; strobes are computed one
    // cycle ahead so that every SRAM pin comes straight from a flop.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_gnt       = r_gnt;
        w_we        = r_we;
        w_last      = r_last;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_ce        = 1'b1;
        w_ub        = 1'b1;
        w_lb        = 1'b1;
        w_oe        = 1'b1;
        w_wen       = 1'b1;
        w_doe       = 1'b0;
        w_rsp_valid = 2'b00;
        w_rdata     = r_rdata;
        w_ready     = 2'b00;
        w_sel       = 1'b0;
        w_be        = 2'b00;

        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    // On a tie the requester that did not win last time goes first.
                    if (bus.req_valid == 2'b11) begin
                        w_sel = ~r_last;
                    end else begin
                        w_sel = bus.req_valid[1];
                    end
                    w_ready[w_sel] = 1'b1;
                    w_gnt   = w_sel;
                    w_last  = w_sel;
                    w_we    = bus.req_we[w_sel];
                    w_addr  = w_sel ? bus.req_addr1  : bus.req_addr0;
                    w_wdata = w_sel ? bus.req_wdata1 : bus.req_wdata0;
                    w_be    = w_sel ? bus.req_be1    : bus.req_be0;
                    w_cnt   = w_we ? WR_LOAD : RD_LOAD;
                    w_ce    = 1'b0;
                    w_ub    = ~w_be[1];
                    w_lb    = ~w_be[0];
                    w_oe    = w_we;
                    w_doe   = w_we;
                    // WE stays high on the last access cycle for address/data hold.
                    w_wen   = ~w_we | (w_cnt == 4'd0);
                    w_state = ST_ACCESS;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                w_ce  = r_ce;
                w_ub  = r_ub;
                w_lb  = r_lb;
                w_oe  = r_oe;
                w_doe = r_doe;
                if (r_cnt == 4'd0) begin
                    w_state        = ST_DONE;
                    w_rsp_valid[r_gnt] = 1'b1;
                    w_ce           = 1'b1;
                    w_ub           = 1'b1;
                    w_lb           = 1'b1;
                    w_oe           = 1'b1;
                    w_doe          = 1'b0;
                    w_wen          = 1'b1;
                    if (!r_we) begin
                        w_rdata = i_Data_from_SRAM;
                    end else begin
                        w_rdata = r_rdata;
                    end
                end else begin
                    w_cnt = r_cnt - 4'd1;
                    w_wen = ~r_we | (w_cnt == 4'd0);
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered SRAM strobes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_gnt       <= 1'b0;
            r_we        <= 1'b0;
            r_last      <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= 16'h0000;
            r_ce        <= 1'b1;
            r_ub        <= 1'b1;
            r_lb        <= 1'b1;
            r_oe        <= 1'b1;
            r_wen       <= 1'b1;
            r_doe       <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rdata     <= 16'h0000;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_gnt       <= w_gnt;
            r_we        <= w_we;
            r_last      <= w_last;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_ce        <= w_ce;
            r_ub        <= w_ub;
            r_lb        <= w_lb;
            r_oe        <= w_oe;
            r_wen       <= w_wen;
            r_doe       <= w_doe;
            r_rsp_valid <= w_rsp_valid;
            r_rdata     <= w_rdata;
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rdata;
    assign o_Mem_ADDR      = r_addr;
    assign o_Data_to_SRAM  = r_wdata;
    assign o_Data_oe       = r_doe;
    assign o_Mem_CE        = r_ce;
    assign o_Mem_UB        = r_ub;
    assign o_Mem_LB        = r_lb;
    assign o_Mem_OE        = r_oe;
    assign o_Mem_WE        = r_wen;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter with RD_CYCLES=2, WR_CYCLES=3. A small
// asynchronous SRAM model answers reads and commits writes on the end of the
// write strobe; ref_mem and ref_last hold the expected memory contents and
// round-robin pointer derived from the access rules.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
    localparam int AW  = 20;
    localparam int RDC = 2;
    localparam int WRC = 3;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    sram_arbiter_if #(.ADDR_W(AW)) bus();

    logic [AW-1:0] mem_addr;
    logic [15:0]   d_to, d_from;
    logic          d_oe, ce, ub, lb, oe, we_n;

    sram_arbiter #(.ADDR_W(AW), .RD_CYCLES(RDC), .WR_CYCLES(WRC)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .bus              (bus),
        .o_Mem_ADDR       (mem_addr),
        .o_Data_to_SRAM   (d_to),
        .o_Data_oe        (d_oe),
        .i_Data_from_SRAM (d_from),
        .o_Mem_CE         (ce),
        .o_Mem_UB         (ub),
        .o_Mem_LB         (lb),
        .o_Mem_OE         (oe),
        .o_Mem_WE         (we_n)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [15:0]   sram    [0:255];
    logic [15:0]   ref_mem [0:255];
    logic          ref_last;
    logic          sram_init = 1'b0;
    logic [AW-1:0] watch_addr = '0;
    int            touch_cnt = 0;
    logic          p_ce = 1'b1, p_wen = 1'b1, p_ub = 1'b1, p_lb = 1'b1;
    logic [AW-1:0] p_addr = '0;
    logic [15:0]   p_data = 16'h0000;

    function automatic logic [15:0] pat(int i);
        if (i == 16) return 16'h1234;
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    // SRAM model: reads are combinational, writes land when WE or CE rises.
    assign d_from = (!ce && !oe) ? sram[mem_addr[7:0]] : 16'hDEAD;

    always @(posedge Clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 256; i++) sram[i] <= pat(i);
            sram_init <= 1'b1;
        end else if (!p_ce && !p_wen && (we_n || ce)) begin
            if (!p_ub) sram[p_addr[7:0]][15:8] <= p_data[15:8];
            if (!p_lb) sram[p_addr[7:0]][7:0]  <= p_data[7:0];
        end
        p_ce   <= ce;
        p_wen  <= we_n;
        p_ub   <= ub;
        p_lb   <= lb;
        p_addr <= mem_addr;
        p_data <= d_to;
        if (!ce && mem_addr == watch_addr) touch_cnt <= touch_cnt + 1;
    end

    function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] wd, logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[1]) r[15:8] = wd[15:8];
        if (be[0]) r[7:0]  = wd[7:0];
        return r;
    endfunction

    task automatic drive_idle_inputs();
        bus.req_valid  = 2'b00;
        bus.req_we     = 2'b00;
        bus.req_addr0  = '0;
        bus.req_addr1  = '0;
        bus.req_wdata0 = 16'h0000;
        bus.req_wdata1 = 16'h0000;
        bus.req_be0    = 2'b00;
        bus.req_be1    = 2'b00;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        ref_last = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        vec_cnt++;
        if ({ce, ub, lb, oe, we_n, d_oe} !== 6'b111110) begin
            err_cnt++; $display("FAIL reset_strobes: got %b expected %b", {ce, ub, lb, oe, we_n, d_oe}, 6'b111110);
        end
        vec_cnt++;
        if (mem_addr !== 20'h00000 || d_to !== 16'h0000) begin
            err_cnt++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", mem_addr, d_to);
        end
        vec_cnt++;
        if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_rdata !== 16'h0000) begin
            err_cnt++; $display("FAIL reset_handshake: got %b/%b/%h expected 00/00/0000", bus.req_ready, bus.rsp_valid, bus.rsp_rdata);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_single_read();
        @(negedge Clk);
        bus.req_we = 2'b00; bus.req_addr0 = 20'h00010; bus.req_be0 = 2'b11; bus.req_valid = 2'b01;
        #1;
        vec_cnt++;
        if (bus.req_ready !== 2'b01) begin
            err_cnt++; $display("FAIL read_ready: got %b expected 01", bus.req_ready);
        end
        ref_last = 1'b0;
        for (int k = 1; k <= RDC; k++) begin
            @(negedge Clk);
            bus.req_valid = 2'b00;
            vec_cnt++;
            if ({ce, oe} !== 2'b00 || mem_addr !== 20'h00010) begin
                err_cnt++; $display("FAIL read_access_t%0d: got ce/oe %b addr %h expected 00 addr 00010", k, {ce, oe}, mem_addr);
            end
        end
        @(negedge Clk);
        vec_cnt++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 16'h1234) begin
            err_cnt++; $display("FAIL read_rsp: got %b/%h expected 01/1234", bus.rsp_valid, bus.rsp_rdata);
        end
    endtask

    task automatic test_single_write();
        @(negedge Clk);
        bus.req_we = 2'b10; bus.req_addr1 = 20'h00020; bus.req_wdata1 = 16'hBEEF;
        bus.req_be1 = 2'b11; bus.req_valid = 2'b10;
        #1;
        vec_cnt++;
        if (bus.req_ready !== 2'b10) begin
            err_cnt++; $display("FAIL write_ready: got %b expected 10", bus.req_ready);
        end
        ref_last = 1'b1;
        for (int k = 1; k <= WRC; k++) begin
            @(negedge Clk);
            bus.req_valid = 2'b00;
            vec_cnt++;
            if (we_n !== ((k < WRC) ? 1'b0 : 1'b1) || d_oe !== 1'b1 || d_to !== 16'hBEEF) begin
                err_cnt++; $display("FAIL write_access_t%0d: got we_n %b oe %b data %h", k, we_n, d_oe, d_to);
            end
        end
        @(negedge Clk);
        ref_mem[8'h20] = 16'hBEEF;
        vec_cnt++;
        if (bus.rsp_valid !== 2'b10 || sram[8'h20] !== 16'hBEEF) begin
            err_cnt++; $display("FAIL write_rsp: got %b mem %h expected 10 mem beef", bus.rsp_valid, sram[8'h20]);
        end
    endtask

    task automatic test_byte_enable();
        logic [15:0] exp_word;
        @(negedge Clk);
        bus.req_we = 2'b01; bus.req_addr0 = 20'h00030; bus.req_wdata0 = 16'hAB00;
        bus.req_be0 = 2'b10; bus.req_valid = 2'b01;
        #1;
        ref_last = 1'b0;
        for (int k = 1; k <= WRC; k++) begin
            @(negedge Clk);
            bus.req_valid = 2'b00;
            vec_cnt++;
            if ({ub, lb} !== 2'b01) begin
                err_cnt++; $display("FAIL be_strobes_t%0d: got ub/lb %b expected 01", k, {ub, lb});
            end
        end
        @(negedge Clk);
        exp_word = merge(ref_mem[8'h30], 16'hAB00, 2'b10);
        ref_mem[8'h30] = exp_word;
        vec_cnt++;
        if (sram[8'h30] !== exp_word) begin
            err_cnt++; $display("FAIL be_memory: got %h expected %h", sram[8'h30], exp_word);
        end
    endtask

    task automatic test_random();
        logic [1:0]    vm, ebe;
        logic          g, ewe;
        logic [AW-1:0] eaddr;
        logic [15:0]   ewd;
        int            n_cyc;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            vm = 2'($urandom_range(1, 3));
            bus.req_we     = 2'($urandom_range(0, 3));
            bus.req_addr0  = AW'($urandom_range(0, 255));
            bus.req_addr1  = AW'($urandom_range(0, 255));
            bus.req_wdata0 = 16'($urandom);
            bus.req_wdata1 = 16'($urandom);
            bus.req_be0    = 2'($urandom_range(0, 3));
            bus.req_be1    = 2'($urandom_range(0, 3));
            bus.req_valid  = vm;
            g     = (vm == 2'b11) ? ~ref_last : vm[1];
            ewe   = bus.req_we[g];
            eaddr = g ? bus.req_addr1  : bus.req_addr0;
            ewd   = g ? bus.req_wdata1 : bus.req_wdata0;
            ebe   = g ? bus.req_be1    : bus.req_be0;
            n_cyc = ewe ? WRC : RDC;
            #1;
            vec_cnt++;
            if (bus.req_ready !== (g ? 2'b10 : 2'b01)) begin
                err_cnt++; $display("FAIL rnd_ready_%0d: got %b expected grant %0d", n, bus.req_ready, g);
            end
            ref_last = g;
            for (int k = 1; k <= n_cyc; k++) begin
                @(negedge Clk);
                bus.req_valid = 2'b00;
                vec_cnt++;
                if ({ce, ub, lb, oe, we_n, d_oe} !== {1'b0, ~ebe[1], ~ebe[0], ewe, ~(ewe && k < n_cyc), ewe}
                    || mem_addr !== eaddr || (ewe && d_to !== ewd)) begin
                    err_cnt++;
                    $display("FAIL rnd_access_%0d_t%0d: got %b addr %h data %h expected %b addr %h data %h", n, k,
                             {ce, ub, lb, oe, we_n, d_oe}, mem_addr, d_to,
                             {1'b0, ~ebe[1], ~ebe[0], ewe, ~(ewe && k < n_cyc), ewe}, eaddr, ewd);
                end
            end
            @(negedge Clk);
            if (ewe) ref_mem[eaddr[7:0]] = merge(ref_mem[eaddr[7:0]], ewd, ebe);
            vec_cnt++;
            if (bus.rsp_valid !== (g ? 2'b10 : 2'b01) || (!ewe && bus.rsp_rdata !== ref_mem[eaddr[7:0]])
                || sram[eaddr[7:0]] !== ref_mem[eaddr[7:0]] || {ce, we_n, oe, d_oe} !== 4'b1110) begin
                err_cnt++;
                $display("FAIL rnd_rsp_%0d: got rsp %b rdata %h mem %h expected grant %0d word %h", n,
                         bus.rsp_valid, bus.rsp_rdata, sram[eaddr[7:0]], g, ref_mem[eaddr[7:0]]);
            end
        end
    endtask

    task automatic test_contention();
        int          nt, rt, ngr, drop_t;
        logic        g, pg;
        logic [1:0]  exp_rdy, exp_rsp;
        apply_reset();
        bus.req_we = 2'b10;
        bus.req_addr0 = 20'h00040; bus.req_be0 = 2'b11;
        bus.req_addr1 = 20'h00041; bus.req_be1 = 2'b01; bus.req_wdata1 = 16'hC3C3;
        nt = 0; rt = -1; ngr = 0; drop_t = -1; g = ~ref_last; pg = 1'b0;
        @(negedge Clk);
        bus.req_valid = 2'b11;
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge Clk);
            if (c == drop_t) bus.req_valid = 2'b00;
            #1;
            exp_rdy = 2'b00;
            if (c == nt && ngr < 6) exp_rdy[g] = 1'b1;
            exp_rsp = 2'b00;
            if (c == rt) exp_rsp[pg] = 1'b1;
            vec_cnt++;
            if (bus.req_ready !== exp_rdy || bus.rsp_valid !== exp_rsp
                || (c == rt && !pg && bus.rsp_rdata !== ref_mem[8'h40])) begin
                err_cnt++;
                $display("FAIL contention_c%0d: got ready %b rsp %b expected ready %b rsp %b", c,
                         bus.req_ready, bus.rsp_valid, exp_rdy, exp_rsp);
            end
            if (exp_rdy != 2'b00) begin
                pg = g;
                rt = c + (g ? WRC : RDC) + 1;
                nt = c + (g ? WRC : RDC) + 2;
                ref_last = g;
                g = ~g;
                ngr++;
                if (ngr == 6) drop_t = c + 1;
            end
        end
        ref_mem[8'h41] = merge(ref_mem[8'h41], 16'hC3C3, 2'b01);
        vec_cnt++;
        if (sram[8'h41] !== ref_mem[8'h41]) begin
            err_cnt++; $display("FAIL contention_memory: got %h expected %h", sram[8'h41], ref_mem[8'h41]);
        end
    endtask

    task automatic test_withdraw();
        int snap;
        watch_addr = 20'h00070;
        @(negedge Clk);
        snap = touch_cnt;
        bus.req_we = 2'b10; bus.req_addr1 = 20'h00071; bus.req_wdata1 = 16'h5555;
        bus.req_be1 = 2'b11; bus.req_addr0 = 20'h00070; bus.req_be0 = 2'b11;
        bus.req_valid = 2'b10;
        #1;
        ref_last = 1'b1;
        for (int k = 1; k <= WRC + 2; k++) begin
            @(negedge Clk);
            if (k == 1) bus.req_valid = 2'b01;
            #1;
            vec_cnt++;
            if (bus.req_ready !== 2'b00) begin
                err_cnt++; $display("FAIL withdraw_ready_t%0d: got %b expected 00", k, bus.req_ready);
            end
            if (k == WRC + 1) bus.req_valid = 2'b00;
        end
        ref_mem[8'h71] = 16'h5555;
        vec_cnt++;
        if (touch_cnt != snap) begin
            err_cnt++; $display("FAIL withdraw_touch: got %0d accesses expected 0", touch_cnt - snap);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge Clk);
        bus.req_we = 2'b10; bus.req_addr1 = 20'h00050; bus.req_wdata1 = 16'h0F0F;
        bus.req_be1 = 2'b11; bus.req_valid = 2'b10;
        #1;
        @(negedge Clk);
        bus.req_valid = 2'b00;
        Reset = 1'b1;
        @(negedge Clk);
        vec_cnt++;
        if ({ce, ub, lb, oe, we_n, d_oe} !== 6'b111110 || bus.rsp_valid !== 2'b00 || mem_addr !== 20'h00000) begin
            err_cnt++; $display("FAIL rstmid_strobes: got %b rsp %b addr %h expected 111110 00 0",
                                {ce, ub, lb, oe, we_n, d_oe}, bus.rsp_valid, mem_addr);
        end
        Reset = 1'b0;
        ref_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            vec_cnt++;
            if (bus.rsp_valid !== 2'b00 || {ce, we_n} !== 2'b11) begin
                err_cnt++; $display("FAIL rstmid_quiet_%0d: got rsp %b ce/we %b expected 00 11", k, bus.rsp_valid, {ce, we_n});
            end
        end
        bus.req_we = 2'b00; bus.req_addr0 = 20'h00060; bus.req_addr1 = 20'h00061;
        bus.req_valid = 2'b11;
        #1;
        vec_cnt++;
        if (bus.req_ready !== 2'b01) begin
            err_cnt++; $display("FAIL rstmid_tie: got %b expected 01", bus.req_ready);
        end
        for (int k = 1; k <= RDC; k++) begin
            @(negedge Clk);
            bus.req_valid = 2'b00;
        end
        @(negedge Clk);
        vec_cnt++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== ref_mem[8'h60]) begin
            err_cnt++; $display("FAIL rstmid_rsp: got %b/%h expected 01/%h", bus.rsp_valid, bus.rsp_rdata, ref_mem[8'h60]);
        end
    endtask

    initial begin
        Reset = 1'b1;
        drive_idle_inputs();
        ref_last = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        repeat (2) @(negedge Clk);
        test_reset();
        test_single_read();
        test_single_write();
        test_byte_enable();
        test_random();
        test_contention();
        test_withdraw();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer for the shared 16-bit asynchronous SRAM. Requester 0 is the CPU memory path (MAR/MDR side); requester 1 is the debug/IO loader. The block grants one request at a time by round-robin, runs the multi-cycle SRAM read or write with correct active-low strobes, and returns a one-cycle response pulse. It owns every Mem_* control pin, so no other block drives them.

## Interface
- ADDR_W, 20: SRAM word-address width.
- RD_CYCLES, 2: cycles in the ACCESS state for a read; legal range 1..15.
- WR_CYCLES, 2: cycles in the ACCESS state for a write; legal range 2..15.
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high.
- req_valid  in  2  bit i: requester i has a pending request.
- req_we  in  2  bit i: 1 = write, 0 = read.
- req_addr0, req_addr1  in  ADDR_W each  word address.
- req_wdata0, req_wdata1  in  16 each  write data.
- req_be0, req_be1  in  2 each  byte enables, active-high; [1] = upper byte, [0] = lower byte.
- req_ready  out  2  one-hot pulse; the request is accepted in the cycle the bit is high.
- rsp_valid  out  2  one-hot pulse; the access has completed.
- rsp_rdata  out  16  read data; valid while rsp_valid is high and held afterwards.
- Mem_ADDR  out  ADDR_W  SRAM address.
- Data_to_SRAM  out  16  write data.
- Data_oe  out  1  high while the pad driver must drive Data_to_SRAM onto the bus.
- Data_from_SRAM  in  16  SRAM read bus.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low.

## Operation
- **States.** IDLE, ACCESS, DONE.
- **IDLE.**
  - If any req_valid bit is set, grant one requester.
  - The grant is combinational: req_ready[g] is high in the same cycle.
  - Latch g, we, addr, wdata and be for the granted requester.
  - Load the counter with RD_CYCLES-1 or WR_CYCLES-1, then go to ACCESS.
- **Arbitration.**
  - Only one requester valid: grant it.
  - Both valid: grant the requester that was not granted last.
  - The last-grant pointer updates only on acceptance. After reset it equals 1, so requester 0 wins the first tie.
- **ACCESS.** Outputs are driven from the latched request:
  - Mem_CE = 0.
  - Mem_UB = ~be[1], Mem_LB = ~be[0].
  - Mem_ADDR = addr.
  - The counter decrements each cycle; leave ACCESS when it is 0.
- **ACCESS, read.**
  - Mem_OE = 0 and Data_oe = 0 on every ACCESS cycle.
  - On the last ACCESS cycle, register Data_from_SRAM into rsp_rdata.
- **ACCESS, write.**
  - Mem_OE = 1 and Data_oe = 1 on every ACCESS cycle.
  - Mem_WE = 0 on every ACCESS cycle except the last. On the last cycle Mem_WE = 1 while address and data are still held, which gives hold time.
- **DONE.**
  - rsp_valid[g] = 1 for exactly one cycle.
  - All strobes return to their idle values.
  - Next state is IDLE; no request is accepted in DONE.
- **Idle output values** (IDLE, DONE, and after reset):
  - Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE = 1.
  - Data_oe = 0.
  - req_ready = 0; rsp_valid = 0 except the DONE pulse.
  - Mem_ADDR and Data_to_SRAM hold their last values; both are 0 after reset.
- **Requester rules.**
  - Fields must be held stable while req_valid is high and until req_ready.
  - Deasserting req_valid before req_ready withdraws the request and is legal.
  - Fields are sampled only at acceptance, so they may change freely after req_ready.
- **be = 00.** The access runs with full timing but neither byte is strobed. A response is still issued; a read returns rsp_rdata = Data_from_SRAM as sampled.

## Timing
- **Request accepted in cycle t:**
  - ACCESS covers t+1 … t+N, with N = RD_CYCLES or WR_CYCLES.
  - rsp_valid is high at t+N+1.
  - The earliest next acceptance is t+N+2.
- **Throughput.** One access per N+2 cycles. With both requesters saturating, grants strictly alternate.
- **Reset.**
  - Reset high at any rising edge forces IDLE, the idle output values, pointer = 1 and rsp_rdata = 0.
  - An in-flight access is aborted with no rsp_valid, and no partial write strobe remains after that edge.
- **Same-cycle events.** A new req_valid arriving during DONE is not accepted until the following IDLE cycle.

## Test plan
- **Single read.** RD_CYCLES=2, req0 read addr 0x00010, SRAM model returns 0x1234. Required:
  - req_ready[0] at t.
  - Mem_OE=0 and Mem_CE=0 at t+1, t+2.
  - rsp_valid[0] with rsp_rdata=0x1234 at t+3.
- **Single write.** WR_CYCLES=3, req1 write 0xBEEF to 0x00020, be=11. Required:
  - Mem_WE=0 at t+1, t+2 and 1 at t+3.
  - Data_oe=1 at t+1..t+3.
  - The model holds 0xBEEF; rsp_valid[1] at t+4.
- **Byte enable.** Write 0xAB00, be=10. Required: Mem_UB=0 and Mem_LB=1 during ACCESS; only the upper byte changes in the model.
- **Contention.** Both requesters valid continuously from reset for 6 accesses. Required: grant order 0,1,0,1,0,1, with acceptances spaced exactly N+2 cycles apart.
- **Reset mid-write.** Reset asserted at t+1 of a 3-cycle write. Required:
  - From t+2, all strobes = 1, Data_oe = 0, state IDLE.
  - No rsp_valid; the next tie is granted to requester 0.
- **Withdrawn request.** req0 asserted while req1's access is in progress, then dropped before IDLE. Required: no req_ready[0] and no access to req0's address.
